// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit (master) and the
// instruction memory (slave).
interface instruction_fetch_unit_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_ack;
   logic [DATA_WIDTH-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the PC loop, fetches over a variable-latency req/ack bus and loads IF/ID.
// Optional misaligned-PC trap is enabled by defining IFU_ALIGN_CHECK_EN.
module instruction_fetch_unit #(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           PC_INCREMENT = 4,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD     = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   pc_in,
   input  logic                    branch_taken,
   input  logic [ADDR_WIDTH-1:0]   branch_target,
   input  logic                    stall,
   instruction_fetch_unit_if.master imem,
   output logic                    pc_write,
   output logic [ADDR_WIDTH-1:0]   pc_next,
   output logic                    ifid_valid,
   output logic [DATA_WIDTH-1:0]   ifid_instr,
   output logic [ADDR_WIDTH-1:0]   ifid_pc_plus4,
   output logic                    fetch_misaligned
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] hold_instr;
   logic [ADDR_WIDTH-1:0] hold_pc_plus4;
   logic                  req;
   logic                  acked;
   logic                  fetch_ack;
   logic                  redirect;
   logic                  misalign_now;

   assign pc_inc = pc_in + ADDR_WIDTH'(PC_INCREMENT);

`ifdef IFU_ALIGN_CHECK_EN
   logic misaligned_q;

   assign misalign_now = (state == S_FETCH) && (pc_in[1:0] != 2'b00);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)             misaligned_q <= 1'b0;
      else if (branch_taken)  misaligned_q <= 1'b0;
      else if (misalign_now)  misaligned_q <= 1'b1;
   end

   assign fetch_misaligned = misaligned_q;
`else
   assign misalign_now     = 1'b0;
   assign fetch_misaligned = 1'b0;
`endif

   always_comb begin
      req      = 1'b0;
      req_addr = addr_q;
      case (state)
         S_FETCH: begin
            req      = !misalign_now;
            req_addr = pc_in;
         end
         S_DRAIN: req = 1'b1;
         default: ;
      endcase
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = req_addr;

   assign acked     = req && imem.imem_ack;
   assign fetch_ack = (state == S_FETCH) && acked;
   assign redirect  = branch_taken && (state != S_IDLE);
   assign pc_write  = redirect || fetch_ack;
   assign pc_next   = redirect ? branch_target : pc_inc;

   // A redirect with no request outstanding (acked, or blocked by misalignment) has nothing to drain.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_FETCH;
         S_FETCH: begin
            if (redirect)           state_nxt = (acked || !req) ? S_FETCH : S_DRAIN;
            else if (acked && stall) state_nxt = S_HOLD;
         end
         S_HOLD:  if (redirect || !stall) state_nxt = S_FETCH;
         S_DRAIN: if (!redirect && acked) state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         addr_q        <= '0;
         hold_instr    <= '0;
         hold_pc_plus4 <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH) addr_q <= req_addr;
         if (fetch_ack && stall && !branch_taken) begin
            hold_instr    <= imem.imem_rdata;
            hold_pc_plus4 <= pc_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ifid_valid    <= 1'b0;
         ifid_instr    <= NOP_WORD;
         ifid_pc_plus4 <= '0;
      end else if (redirect) begin
         ifid_valid <= 1'b0;
         ifid_instr <= NOP_WORD;
      end else if (!stall) begin
         if (fetch_ack) begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= imem.imem_rdata;
            ifid_pc_plus4 <= pc_inc;
         end else if (state == S_HOLD) begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= hold_instr;
            ifid_pc_plus4 <= hold_pc_plus4;
         end else begin
            ifid_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that consumes the program counter's current value and returns next-PC and pc-write control to it, closing the PC loop. Issues requests to instruction memory over a req/ack handshake with variable latency. Loads the returned word into the IF/ID pipeline register. Supports hazard-unit stall, and branch redirect with flush of the fetch in flight.

Parameters:
ADDR_WIDTH, 32, PC and instruction-memory address width
DATA_WIDTH, 32, instruction word width
PC_INCREMENT, 4, sequential PC step in bytes
NOP_WORD, 32'h00000000, value loaded into ifid_instr on reset and on flush

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_in  in  ADDR_WIDTH  current PC from the program counter's output
branch_taken  in  1  redirect request from the branch/jump resolver
branch_target  in  ADDR_WIDTH  redirect address
stall  in  1  hazard-unit stall: IF/ID must hold its contents
imem_req  out  1  instruction-memory request
imem_addr  out  ADDR_WIDTH  request address; stable while imem_req=1 and not acked
imem_ack  in  1  memory completion; meaningful only while imem_req=1
imem_rdata  in  DATA_WIDTH  instruction word, valid in the imem_ack cycle
pc_write  out  1  program counter load enable (combinational)
pc_next  out  ADDR_WIDTH  program counter load value (combinational)
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  DATA_WIDTH  IF/ID instruction
ifid_pc_plus4  out  ADDR_WIDTH  fetched address + PC_INCREMENT
fetch_misaligned  out  1  misalignment flag (optional feature; tied 0 when the feature is off)

Behaviour:
- Reset (reset=0, async) clears state and IF/ID:
  - state=IDLE; ifid_valid=0; ifid_instr=NOP_WORD; ifid_pc_plus4=0.
  - Hold buffer cleared; addr_q=0.
  - imem_req=0 and pc_write=0 while in reset.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE:
  - Drives no request.
  - Moves to FETCH on the first clk edge after reset is released.
- FETCH:
  - Drives imem_req=1 and imem_addr=pc_in; addr_q<=imem_addr every cycle.
  - No ack: stay in FETCH, pc_write=0. The PC is unchanged, so the address stays stable.
  - Ack with stall=0:
    - pc_write=1, pc_next=pc_in+PC_INCREMENT.
    - IF/ID loads valid=1, instr=imem_rdata, pc_plus4=pc_in+PC_INCREMENT.
    - Stay in FETCH; the next request uses the new PC in the following cycle. Zero-wait memory sustains 1 instr/cycle.
  - Ack with stall=1:
    - Capture imem_rdata and pc_plus4 into the hold buffer.
    - pc_write=1 with pc_in+PC_INCREMENT; go to HOLD.
- HOLD:
  - imem_req=0; pc_write=0.
  - When stall=0: IF/ID loads from the hold buffer with valid=1, then go to FETCH.
- DRAIN:
  - imem_req=1, imem_addr=addr_q (the orphaned request is kept alive until it completes).
  - On ack, discard the data and go to FETCH. IF/ID is not loaded.
- IF/ID update rule (all states, branch_taken=0):
  - stall=1: IF/ID holds.
  - stall=0 and no instruction delivered that edge: ifid_valid<=0 (bubble); instr and pc_plus4 hold.
- branch_taken=1 (highest priority, overrides stall, any state except IDLE):
  - pc_write=1, pc_next=branch_target.
  - IF/ID flushes: valid=0, instr=NOP_WORD.
  - Hold buffer discarded.
  - Next state:
    - FETCH with no ack this cycle: go to DRAIN.
    - FETCH with ack this cycle: data discarded, stay in FETCH.
    - HOLD: go to FETCH.
    - DRAIN: stay in DRAIN.
- Arithmetic: all PC additions are modulo 2^ADDR_WIDTH; 0xFFFFFFFC+4 wraps to 0.
- pc_next defaults to pc_in+PC_INCREMENT whenever pc_write=0.
- Reset asserted mid-request abandons the request; the memory is also reset.

Optional Feature:
Macro IFU_ALIGN_CHECK_EN.
- Defined:
  - In FETCH, if pc_in[1:0]!=0: no request, pc_write=0, IF/ID bubbles.
  - fetch_misaligned is set and stays set (sticky) until reset or branch_taken.
  - The unit stays in FETCH stuck at that PC until branch_taken redirects it.
- Not defined: no check is made; fetch_misaligned is constant 0.

Test Plan:
- Reset, zero-wait memory returning addr-tagged words (instr = 0xA0000000|addr) -> pc_write each cycle; IF/ID shows 0xA0000000, 0xA0000004, 0xA0000008 with ifid_pc_plus4 4, 8, 12; ifid_valid=1 from the second cycle after reset release.
- Memory latency 3 cycles -> imem_addr stable for 3 cycles, one pc_write per ack, ifid_valid=0 bubbles between instructions.
- stall=1 asserted 1 cycle before the ack of addr 0x10, held 4 cycles -> IF/ID frozen; PC advances to 0x14; on stall release ifid_instr=word@0x10 and ifid_pc_plus4=0x14.
- branch_taken with target 0x100 while a 3-cycle request to 0x20 is pending -> pc_next=0x100 and IF/ID flushed to NOP_WORD; the 0x20 request stays alive on imem_addr until its ack, its data never reaches IF/ID, and the next request is 0x100.
- pc_in=0xFFFFFFFC fetched -> pc_next=0x00000000 and ifid_pc_plus4=0.
- With IFU_ALIGN_CHECK_EN, redirect to 0x102 -> imem_req=0, fetch_misaligned=1; a later branch to 0x200 clears it and fetching resumes.
